store_align_buffer: RTL and testbench

Memory-stage store path, the write-side counterpart of the load extension logic. It takes sb/sh/sw requests, replicates the store data into the correct byte lanes, and generates byte strobes. Aligned stores are queued in a small FIFO that drains to data memory over a valid/ready write port. It also flags pending-store address matches so the hazard unit can stall a younger load until its word has been written.

---
 rtl/store_align_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_store_align_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_buffer.sv
// -----------------------------------------------------------------------------
// store_align_buffer
//
// Memory-stage store path. Each sb/sh/sw request is lane-formatted: the store
// data is replicated into every byte lane it may land in, and a byte-strobe
// mask is produced. Legal, aligned stores go into a small FIFO. The FIFO drains
// to data memory in program order over a valid/ready write port. While a store
// is still buffered, a load to the same 32-bit word raises load_hit so that the
// hazard unit can hold that load.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   store_valid   : M-stage store request this cycle
//   StoreTypeM    : store funct3 (000 sb, 001 sh, 010 sw)
//   store_addr    : store byte address
//   store_data    : rs2 value to be stored
//   store_stall   : buffer full, request not taken, pipeline must hold
//   store_err     : misaligned or illegal funct3, request dropped
//   load_valid    : M-stage load request this cycle
//   load_addr     : load byte address
//   load_hit      : a buffered store targets the load's word
//   mem_wvalid    : head entry valid toward data memory
//   mem_wready    : data memory accepts the head entry
//   mem_waddr     : word-aligned write address
//   mem_wdata     : lane-replicated write data
//   mem_wstrb     : byte enables, bit i = byte lane i
//   buf_empty     : no pending entries
//   buf_count     : occupancy
// -----------------------------------------------------------------------------
module store_align_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             store_valid,
  input  logic [2:0]       StoreTypeM,
  input  logic [31:0]      store_addr,
  input  logic [31:0]      store_data,
  output logic             store_stall,
  output logic             store_err,
  input  logic             load_valid,
  input  logic [31:0]      load_addr,
  output logic             load_hit,
  output logic             mem_wvalid,
  input  logic             mem_wready,
  output logic [31:0]      mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  output logic             buf_empty,
  output logic [CNT_W-1:0] buf_count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Store-type encodings taken from funct3
  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  // FIFO state
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [DEPTH-1:0] valid_r;
  logic [29:0]      waddr_r [DEPTH];
  logic [31:0]      wdata_r [DEPTH];
  logic [3:0]       wstrb_r [DEPTH];

  // Formatting and control
  logic [31:0]      fmt_data_s;
  logic [3:0]       fmt_strb_s;
  logic             misalign_s;
  logic             illegal_s;
  logic             err_s;
  logic             full_s;
  logic             empty_s;
  logic             enq_s;
  logic             deq_s;
  logic             hit_any_s;

  // Lane replication, strobe generation and alignment / funct3 legality
  always_comb begin
    fmt_data_s = 32'h0000_0000;
    fmt_strb_s = 4'b0000;
    misalign_s = 1'b0;
    illegal_s  = 1'b0;
    case (StoreTypeM)
      ST_SB: begin
        fmt_data_s = {4{store_data[7:0]}};
        fmt_strb_s = 4'b0001 << store_addr[1:0];
      end
      ST_SH: begin
        fmt_data_s = {2{store_data[15:0]}};
        if (store_addr[1]) begin
          fmt_strb_s = 4'b1100;
        end else begin
          fmt_strb_s = 4'b0011;
        end
        misalign_s = store_addr[0];
      end
      ST_SW: begin
        fmt_data_s = store_data;
        fmt_strb_s = 4'b1111;
        misalign_s = (store_addr[1:0] != 2'b00);
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Handshake decode: an erroring store is rejected even when the buffer is
  // full, and a dequeue in this cycle never frees a slot for this cycle's store
  always_comb begin
    full_s      = (count_r == CNT_W'(DEPTH));
    empty_s     = (count_r == {CNT_W{1'b0}});
    err_s       = store_valid & (misalign_s | illegal_s);
    store_err   = err_s;
    store_stall = store_valid & full_s & ~err_s;
    enq_s       = store_valid & ~full_s & ~err_s;
    deq_s       = ~empty_s & mem_wready;
  end

  // Word-match search over buffered entries; the store being enqueued this
  // cycle is not yet in valid_r, and the entry leaving this cycle still is
  always_comb begin
    hit_any_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i] && (waddr_r[i] == load_addr[31:2])) begin
        hit_any_s = 1'b1;
      end else begin
        hit_any_s = hit_any_s;
      end
    end
    load_hit = load_valid & hit_any_s;
  end

  // Head-entry presentation toward memory and occupancy status
  always_comb begin
    mem_wvalid = ~empty_s;
    mem_waddr  = {waddr_r[head_r], 2'b00};
    mem_wdata  = wdata_r[head_r];
    mem_wstrb  = wstrb_r[head_r];
    buf_empty  = empty_s;
    buf_count  = count_r;
  end

  // Pointer and occupancy update; power-of-2 depth lets pointers wrap freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry valid flags: set at the tail on enqueue, cleared at the head on
  // dequeue; tail and head never coincide on a slot when both happen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_s && (tail_r == PTR_W'(i))) begin
          valid_r[i] <= 1'b1;
        end else if (deq_s && (head_r == PTR_W'(i))) begin
          valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Entry payload storage, written at the tail on enqueue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        waddr_r[i] <= 30'h0000_0000;
        wdata_r[i] <= 32'h0000_0000;
        wstrb_r[i] <= 4'b0000;
      end
    end else begin
      if (enq_s) begin
        waddr_r[tail_r] <= store_addr[31:2];
        wdata_r[tail_r] <= fmt_data_s;
        wstrb_r[tail_r] <= fmt_strb_s;
      end
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
module tb_store_align_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             store_valid;
  logic [2:0]       StoreTypeM;
  logic [31:0]      store_addr;
  logic [31:0]      store_data;
  logic             store_stall;
  logic             store_err;
  logic             load_valid;
  logic [31:0]      load_addr;
  logic             load_hit;
  logic             mem_wvalid;
  logic             mem_wready;
  logic [31:0]      mem_waddr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;

  store_align_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .store_valid(store_valid), .StoreTypeM(StoreTypeM),
    .store_addr(store_addr), .store_data(store_data),
    .store_stall(store_stall), .store_err(store_err),
    .load_valid(load_valid), .load_addr(load_addr), .load_hit(load_hit),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .buf_empty(buf_empty), .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  vec_t tbl [11];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    store_valid = 1'b1;
    StoreTypeM  = t;
    store_addr  = a;
    store_data  = d;
  endtask

  // Memory-side scoreboard: every completed handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && mem_wvalid && mem_wready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h, expected no write", mem_waddr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mem_waddr", mem_waddr, e.a);
        chk("mem_wdata", mem_wdata, e.d);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e.s));
      end
    end
  end

  task automatic wait_drain(input string nm);
    int ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (buf_empty && sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{3'b000, 32'h0000_1003, 32'hAABB_CC5A, 1'b0, 32'h0000_1000, 32'h5A5A_5A5A, 4'b1000};
    tbl[1]  = '{3'b000, 32'h0000_1000, 32'h0000_0011, 1'b0, 32'h0000_1000, 32'h1111_1111, 4'b0001};
    tbl[2]  = '{3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    tbl[3]  = '{3'b001, 32'h0000_2001, 32'h0000_BEEF, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    tbl[4]  = '{3'b001, 32'h0000_2000, 32'h1234_5678, 1'b0, 32'h0000_2000, 32'h5678_5678, 4'b0011};
    tbl[5]  = '{3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111};
    tbl[6]  = '{3'b010, 32'h0000_3002, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    tbl[7]  = '{3'b011, 32'h0000_3000, 32'h0000_0001, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    tbl[8]  = '{3'b100, 32'h0000_3000, 32'h0000_0002, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};
    tbl[9]  = '{3'b000, 32'h0000_1001, 32'h0000_0077, 1'b0, 32'h0000_1000, 32'h7777_7777, 4'b0010};
    tbl[10] = '{3'b000, 32'h0000_1002, 32'hFFFF_FF9C, 1'b0, 32'h0000_1000, 32'h9C9C_9C9C, 4'b0100};

    rst_n = 1'b0; store_valid = 1'b0; StoreTypeM = 3'b000; store_addr = 32'h0;
    store_data = 32'h0; load_valid = 1'b0; load_addr = 32'h0; mem_wready = 1'b1;

    // Reset state
    #12;
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_count", 32'(buf_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Table: one request per cycle with memory always ready
    for (int i = 0; i < 11; i++) begin
      drive_store(tbl[i].typ, tbl[i].addr, tbl[i].data);
      @(negedge clk);
      chk("store_err", 32'(store_err), 32'(tbl[i].err));
      chk("store_stall", 32'(store_stall), 32'd0);
      chk("buf_count", 32'(buf_count), (i > 0 && !tbl[i-1].err) ? 32'd1 : 32'd0);
      chk("wvalid_lat", 32'(mem_wvalid), (i > 0 && !tbl[i-1].err) ? 32'd1 : 32'd0);
      if (!tbl[i].err) sb_q.push_back('{tbl[i].waddr, tbl[i].wdata, tbl[i].strb});
    end
    @(posedge clk); #1; store_valid = 1'b0;
    wait_drain("drain_table");

    // Fill with memory stalled, fifth store must stall
    @(posedge clk); #1; mem_wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_store(3'b010, 32'h10 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      @(negedge clk);
      if (i < 4) begin
        chk("fill_stall", 32'(store_stall), 32'd0);
        sb_q.push_back('{32'h10 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'b1111});
      end else begin
        chk("full_stall", 32'(store_stall), 32'd1);
        chk("full_count", 32'(buf_count), 32'd4);
      end
    end
    // Dequeue in the same cycle does not free room for that cycle's store
    @(posedge clk); #1; mem_wready = 1'b1;
    @(negedge clk);
    chk("deq_stall", 32'(store_stall), 32'd1);
    chk("deq_count", 32'(buf_count), 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("retry_stall", 32'(store_stall), 32'd0);
    chk("retry_count", 32'(buf_count), 32'd3);
    sb_q.push_back('{32'h20, 32'hC0DE_0004, 4'b1111});
    @(posedge clk); #1; store_valid = 1'b0;
    @(negedge clk);
    chk("enq_deq_count", 32'(buf_count), 32'd3);
    wait_drain("drain_full");

    // Load-hit detection
    @(posedge clk); #1; mem_wready = 1'b0;
    drive_store(3'b010, 32'h40, 32'h4040_4040);
    load_valid = 1'b1; load_addr = 32'h40;
    @(negedge clk);
    chk("hit_same_cycle", 32'(load_hit), 32'd0);
    sb_q.push_back('{32'h40, 32'h4040_4040, 4'b1111});
    @(posedge clk); #1; store_valid = 1'b0; load_addr = 32'h43;
    @(negedge clk);
    chk("hit_0x43", 32'(load_hit), 32'd1);
    @(posedge clk); #1; load_addr = 32'h44;
    @(negedge clk);
    chk("hit_0x44", 32'(load_hit), 32'd0);
    @(posedge clk); #1; load_valid = 1'b0; load_addr = 32'h40;
    @(negedge clk);
    chk("hit_no_load", 32'(load_hit), 32'd0);
    @(posedge clk); #1; load_valid = 1'b1; mem_wready = 1'b1;
    @(negedge clk);
    chk("hit_handshake", 32'(load_hit), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hit_after_drain", 32'(load_hit), 32'd0);
    load_valid = 1'b0;

    // Reset with three entries pending
    @(posedge clk); #1; mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(3'b010, 32'h80 + 32'(i * 4), 32'h8800_0000 + 32'(i));
      @(negedge clk);
      sb_q.push_back('{32'h80 + 32'(i * 4), 32'h8800_0000 + 32'(i), 4'b1111});
    end
    @(posedge clk); #1; store_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(buf_count), 32'd3);
    #2; rst_n = 1'b0;
    #1;
    chk("mid_rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("mid_rst_count", 32'(buf_count), 32'd0);
    chk("mid_rst_empty", 32'(buf_empty), 32'd1);
    sb_q.delete();
    #1; rst_n = 1'b1; mem_wready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_wvalid", 32'(mem_wvalid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
